// File: rtl/hms_ctrl_fsm.sv
// HMS clock control: push-button conditioning, CLOCK/SETUP sequencing and single-cycle increment enables.
// Optional field blinking on o_digit_mask is built when HMS_CTRL_BLINK_EN is defined.
module hms_ctrl_fsm #(
   parameter int SAMPLE_DIV = 500000,
   parameter int TICK_DIV   = 50000000,
   parameter int BLINK_DIV  = 12500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_sw0,
   input  logic       i_sw1,
   input  logic       i_sw2,
   input  logic       i_max_hit_sec,
   input  logic       i_max_hit_min,
   output logic       o_mode,
   output logic [1:0] o_position,
   output logic       o_sec_inc,
   output logic       o_min_inc,
   output logic       o_hour_inc,
   output logic       o_tick,
   output logic [5:0] o_digit_mask
);

   // state    | meaning
   // ST_CLOCK | time runs from the seconds tick and counter carries
   // ST_SETUP | time frozen; sw1 selects field, sw2 increments it
   typedef enum logic {
      ST_CLOCK = 1'b0,
      ST_SETUP = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      POS_SEC  = 2'd0,
      POS_MIN  = 2'd1,
      POS_HOUR = 2'd2
   } pos_t;

   localparam int SCW = $clog2(SAMPLE_DIV + 1);
   localparam int TCW = $clog2(TICK_DIV + 1);

   state_t         state, state_nxt;
   pos_t           pos, pos_nxt;
   logic           sec_nxt, min_nxt, hour_nxt;
   logic           leave_setup;

   logic [SCW-1:0] smp_cnt;
   logic           smp_stb;
   logic [2:0]     sw_raw;
   logic [2:0]     hist [3];
   logic [2:0]     armed;
   logic [2:0]     ev;

   logic [TCW-1:0] tick_cnt;
   logic           tick_tc;

   assign smp_stb = (smp_cnt == SCW'(SAMPLE_DIV - 1));
   assign sw_raw  = {i_sw2, i_sw1, i_sw0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp_cnt <= '0;
      end else begin
         smp_cnt <= smp_stb ? '0 : smp_cnt + SCW'(1);
      end
   end

   // A button only arms once it has been seen released, so a press held through reset stays silent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) hist[i] <= 3'b111;
         armed <= '0;
         ev    <= '0;
      end else begin
         ev <= '0;
         if (smp_stb) begin
            for (int i = 0; i < 3; i++) begin
               hist[i] <= {hist[i][1:0], sw_raw[i]};
               if (sw_raw[i]) armed[i] <= 1'b1;
               ev[i] <= armed[i] && ({hist[i][1:0], sw_raw[i]} == 3'b100);
            end
         end
      end
   end

   assign tick_tc     = (tick_cnt == TCW'(TICK_DIV - 1));
   assign leave_setup = (state == ST_SETUP) && (state_nxt == ST_CLOCK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         o_tick   <= 1'b0;
      end else begin
         tick_cnt <= (tick_tc || leave_setup) ? '0 : tick_cnt + TCW'(1);
         o_tick   <= tick_tc;
      end
   end

   // Mode change wins over position/increment events arriving in the same cycle.
   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      sec_nxt   = 1'b0;
      min_nxt   = 1'b0;
      hour_nxt  = 1'b0;
      if (ev[0]) begin
         state_nxt = (state == ST_CLOCK) ? ST_SETUP : ST_CLOCK;
         pos_nxt   = POS_SEC;
      end else if (state == ST_CLOCK) begin
         sec_nxt  = tick_tc;
         min_nxt  = i_max_hit_sec;
         hour_nxt = i_max_hit_min;
      end else begin
         if (ev[2]) begin
            case (pos)
               POS_SEC:  sec_nxt  = 1'b1;
               POS_MIN:  min_nxt  = 1'b1;
               POS_HOUR: hour_nxt = 1'b1;
               default:  sec_nxt  = 1'b0;
            endcase
         end
         if (ev[1]) begin
            case (pos)
               POS_SEC:  pos_nxt = POS_MIN;
               POS_MIN:  pos_nxt = POS_HOUR;
               default:  pos_nxt = POS_SEC;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_CLOCK;
         pos        <= POS_SEC;
         o_sec_inc  <= 1'b0;
         o_min_inc  <= 1'b0;
         o_hour_inc <= 1'b0;
      end else begin
         state      <= state_nxt;
         pos        <= pos_nxt;
         o_sec_inc  <= sec_nxt;
         o_min_inc  <= min_nxt;
         o_hour_inc <= hour_nxt;
      end
   end

   assign o_mode     = state;
   assign o_position = pos;

`ifdef HMS_CTRL_BLINK_EN
   localparam int BCW = $clog2(BLINK_DIV + 1);

   logic [BCW-1:0] blink_cnt;
   logic           blink_tc;
   logic           blink_clr;
   logic           blink_ph, blink_ph_nxt;
   logic [5:0]     field_mask;
   logic [5:0]     mask_q;

   assign blink_tc  = (blink_cnt == BCW'(BLINK_DIV - 1));
   assign blink_clr = (state == ST_SETUP) && !ev[0] && (ev[1] || ev[2]);

   always_comb begin
      blink_ph_nxt = blink_ph;
      if (blink_clr) begin
         blink_ph_nxt = 1'b0;
      end else if (blink_tc) begin
         blink_ph_nxt = ~blink_ph;
      end
      field_mask = 6'b111111;
      case (pos_nxt)
         POS_SEC:  field_mask = 6'b111100;
         POS_MIN:  field_mask = 6'b110011;
         POS_HOUR: field_mask = 6'b001111;
         default:  field_mask = 6'b111111;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
         mask_q    <= 6'b111111;
      end else begin
         blink_cnt <= (blink_clr || blink_tc) ? '0 : blink_cnt + BCW'(1);
         blink_ph  <= blink_ph_nxt;
         mask_q    <= ((state_nxt == ST_SETUP) && blink_ph_nxt) ? field_mask : 6'b111111;
      end
   end

   assign o_digit_mask = mask_q;
`else
   assign o_digit_mask = 6'b111111;
`endif

endmodule
